// File: rtl/msk_rnd_pkg.sv
// Shared definitions for the HPC2 fresh-randomness source: LFSR geometry, seed substitute,
// FSM states and the per-gadget randomness count.
package msk_rnd_pkg;

  localparam int unsigned LFSR_W = 32;
  // Feedback taps for x^32 + x^22 + x^2 + x + 1 (state bits 31, 21, 1, 0)
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SEED_SUBST = 32'hACE1_ACE1;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } rnd_state_e;

  // Fresh bits an HPC2 gadget consumes per cycle for a given share count
  function automatic int unsigned hpc2rnd(input int unsigned shares);
    return (shares * (shares - 1)) / 2;
  endfunction

endpackage

// File: rtl/msk_lfsr_lane.sv
// One 32-bit Fibonacci LFSR lane; a zero seed is replaced so the lane never locks up.
// Exposes the MSB of the next state so the parent can register it alongside the lane.
module msk_lfsr_lane
  import msk_rnd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  input  logic              step_i,
  output logic              msb_nxt_c
);

  logic [LFSR_W-1:0] s_q;
  logic [LFSR_W-1:0] s_d;

  always_comb begin
    s_d = s_q;
    if (load_i) begin
      s_d = (load_val_i == '0) ? SEED_SUBST : load_val_i;
    end else if (step_i) begin
      s_d = {s_q[LFSR_W-2:0], ^(s_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign msb_nxt_c = s_d[LFSR_W-1];

endmodule

// File: rtl/msk_hpc2_rnd_source.sv
// Fresh-randomness source for HPC2 gadgets: NRND seeded LFSR lanes, warm-up, then valid/ready streaming.
// Optional per-seed output limit is enabled by defining MSK_RND_RESEED_LIMIT_EN.
module msk_hpc2_rnd_source
  import msk_rnd_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned WARMUP  = 64,
  parameter int unsigned MAX_OUT = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LFSR_W-1:0]       seed_in,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic                    reseed,
  output logic [hpc2rnd(d)-1:0]   rnd,
  output logic                    rnd_valid,
  input  logic                    rnd_ready,
  output logic                    exhausted
);

  localparam int unsigned NRND   = hpc2rnd(d);
  localparam int unsigned IDX_W  = $clog2(NRND) + 1;
  localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NRND - 1);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);

  rnd_state_e        state_q, state_d;
  logic [IDX_W-1:0]  seed_idx_q, seed_idx_d;
  logic [WCNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              seed_ready_q, seed_ready_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic [NRND-1:0]   rnd_q, rnd_d;
  logic [NRND-1:0]   msb_nxt;
  logic              exhausted_d;
  logic              seed_accept;
  logic              handshake;
  logic              warm_step;
  logic              lane_step;

  assign seed_accept = (state_q == SEED) && seed_valid && seed_ready_q;
  assign handshake   = rnd_valid_q && rnd_ready;
  assign lane_step   = warm_step || handshake;

  always_comb begin
    state_d    = state_q;
    seed_idx_d = seed_idx_q;
    warm_cnt_d = warm_cnt_q;
    warm_step  = 1'b0;
    case (state_q)
      SEED: begin
        if (seed_accept) begin
          seed_idx_d = seed_idx_q + IDX_W'(1);
          if (seed_idx_q == LAST_IDX) begin
            seed_idx_d = '0;
            warm_cnt_d = '0;
            state_d    = (WARMUP == 0) ? RUN : WARM;
          end
        end
      end
      WARM: begin
        if (reseed) begin
          state_d    = SEED;
          seed_idx_d = '0;
        end else begin
          warm_step = 1'b1;
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_d = '0;
            state_d    = RUN;
          end else begin
            warm_cnt_d = warm_cnt_q + WCNT_W'(1);
          end
        end
      end
      RUN: begin
        // A handshake in the same cycle still steps the lanes via lane_step
        if (reseed) begin
          state_d    = SEED;
          seed_idx_d = '0;
        end
      end
      default: begin
        state_d    = SEED;
        seed_idx_d = '0;
      end
    endcase
  end

`ifdef MSK_RND_RESEED_LIMIT_EN
  localparam int unsigned        OUT_W     = 21;
  localparam logic [OUT_W-1:0]   OUT_LIMIT = OUT_W'(MAX_OUT);

  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic             exhausted_q;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (state_d != RUN) begin
      out_cnt_d = '0;
    end else if (handshake) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end
  end

  assign exhausted_d = (state_d == RUN) && (out_cnt_d == OUT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q   <= '0;
      exhausted_q <= 1'b0;
    end else begin
      out_cnt_q   <= out_cnt_d;
      exhausted_q <= exhausted_d;
    end
  end

  assign exhausted = exhausted_q;
`else
  localparam int unsigned unused_max_out = MAX_OUT;

  assign exhausted_d = 1'b0;
  assign exhausted   = 1'b0;
`endif

  assign seed_ready_d = (state_d == SEED);
  assign rnd_valid_d  = (state_d == RUN) && !exhausted_d;
  // Lane state is never exposed unless the output is valid
  assign rnd_d        = rnd_valid_d ? msb_nxt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEED;
      seed_idx_q   <= '0;
      warm_cnt_q   <= '0;
      seed_ready_q <= 1'b0;
      rnd_valid_q  <= 1'b0;
      rnd_q        <= '0;
    end else begin
      state_q      <= state_d;
      seed_idx_q   <= seed_idx_d;
      warm_cnt_q   <= warm_cnt_d;
      seed_ready_q <= seed_ready_d;
      rnd_valid_q  <= rnd_valid_d;
      rnd_q        <= rnd_d;
    end
  end

  for (genvar i = 0; i < NRND; i++) begin : g_lane
    msk_lfsr_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .load_i     (seed_accept && (seed_idx_q == IDX_W'(i))),
      .load_val_i (seed_in),
      .step_i     (lane_step),
      .msb_nxt_c  (msb_nxt[i])
    );
  end

  assign seed_ready = seed_ready_q;
  assign rnd_valid  = rnd_valid_q;
  assign rnd        = rnd_q;

endmodule

// File: tb/tb_msk_hpc2_rnd_source.sv
// Directed bench for msk_hpc2_rnd_source: three instances (d=2/no warm-up, d=3/warm-up 4, d=2/limit 4).
// Limit behaviour is checked against MSK_RND_RESEED_LIMIT_EN when that macro is defined.
module tb_msk_hpc2_rnd_source;

  logic        clk;
  logic        rst;

  logic [31:0] a_seed_in, b_seed_in, c_seed_in;
  logic        a_seed_valid, b_seed_valid, c_seed_valid;
  logic        a_seed_ready, b_seed_ready, c_seed_ready;
  logic        a_reseed, b_reseed, c_reseed;
  logic [0:0]  a_rnd, c_rnd;
  logic [2:0]  b_rnd;
  logic        a_rnd_valid, b_rnd_valid, c_rnd_valid;
  logic        a_rnd_ready, b_rnd_ready, c_rnd_ready;
  logic        a_exhausted, b_exhausted, c_exhausted;

  int checks = 0;
  int errors = 0;

  msk_hpc2_rnd_source #(.d(2), .WARMUP(0)) u_dut_a (
    .clk(clk), .rst(rst), .seed_in(a_seed_in), .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
    .reseed(a_reseed), .rnd(a_rnd), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .exhausted(a_exhausted)
  );

  msk_hpc2_rnd_source #(.d(3), .WARMUP(4)) u_dut_b (
    .clk(clk), .rst(rst), .seed_in(b_seed_in), .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
    .reseed(b_reseed), .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .exhausted(b_exhausted)
  );

  msk_hpc2_rnd_source #(.d(2), .WARMUP(0), .MAX_OUT(4)) u_dut_c (
    .clk(clk), .rst(rst), .seed_in(c_seed_in), .seed_valid(c_seed_valid), .seed_ready(c_seed_ready),
    .reseed(c_reseed), .rnd(c_rnd), .rnd_valid(c_rnd_valid), .rnd_ready(c_rnd_ready), .exhausted(c_exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_seed_in = '0; b_seed_in = '0; c_seed_in = '0;
    a_seed_valid = 1'b0; b_seed_valid = 1'b0; c_seed_valid = 1'b0;
    a_reseed = 1'b0; b_reseed = 1'b0; c_reseed = 1'b0;
    a_rnd_ready = 1'b0; b_rnd_ready = 1'b0; c_rnd_ready = 1'b0;

    // Reset held three cycles
    repeat (3) tick();
    chk("rst_rnd", 32'(a_rnd), 32'h0);
    chk("rst_rnd_valid", 32'(a_rnd_valid), 32'h0);
    chk("rst_seed_ready_a", 32'(a_seed_ready), 32'h0);
    chk("rst_seed_ready_b", 32'(b_seed_ready), 32'h0);
    chk("rst_exhausted", 32'(a_exhausted), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_seed_ready_a", 32'(a_seed_ready), 32'h1);
    chk("post_rst_seed_ready_b", 32'(b_seed_ready), 32'h1);
    chk("post_rst_rnd_valid", 32'(a_rnd_valid), 32'h0);

    // Seed 1, no warm-up: the set bit reaches the MSB after 31 steps
    a_seed_in = 32'h0000_0001; a_seed_valid = 1'b1;
    tick();
    a_seed_valid = 1'b0;
    chk("a_valid_after_seed", 32'(a_rnd_valid), 32'h1);
    chk("a_rnd_after_seed", 32'(a_rnd), 32'h0);
    chk("a_seed_ready_drop", 32'(a_seed_ready), 32'h0);
    a_rnd_ready = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("a_walk_zero", 32'(a_rnd), 32'h0);
      chk("a_walk_valid", 32'(a_rnd_valid), 32'h1);
    end
    tick();
    chk("a_walk_msb", 32'(a_rnd), 32'h1);
    a_rnd_ready = 1'b0;

    // Stall holds the output
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("a_stall_rnd", 32'(a_rnd), 32'h1);
      chk("a_stall_valid", 32'(a_rnd_valid), 32'h1);
    end

    // Reseed concurrent with a handshake
    a_reseed = 1'b1; a_rnd_ready = 1'b1;
    tick();
    a_reseed = 1'b0; a_rnd_ready = 1'b0;
    chk("a_reseed_valid", 32'(a_rnd_valid), 32'h0);
    chk("a_reseed_rnd", 32'(a_rnd), 32'h0);
    chk("a_reseed_seed_ready", 32'(a_seed_ready), 32'h1);
    a_reseed = 1'b1;
    tick();
    a_reseed = 1'b0;
    chk("a_reseed_in_seed_ready", 32'(a_seed_ready), 32'h1);
    chk("a_reseed_in_seed_valid", 32'(a_rnd_valid), 32'h0);

    // Zero seed substitutes ACE1ACE1: MSB sequence 1,0,1,0
    a_seed_in = 32'h0; a_seed_valid = 1'b1;
    tick();
    a_seed_valid = 1'b0;
    chk("a_subst_valid", 32'(a_rnd_valid), 32'h1);
    chk("a_subst_bit31", 32'(a_rnd), 32'h1);
    a_rnd_ready = 1'b1;
    tick();
    chk("a_subst_bit30", 32'(a_rnd), 32'h0);
    chk("a_subst_nobubble", 32'(a_rnd_valid), 32'h1);
    tick();
    chk("a_subst_bit29", 32'(a_rnd), 32'h1);
    tick();
    chk("a_subst_bit28", 32'(a_rnd), 32'h0);
    a_rnd_ready = 1'b0;

    // d=3, warm-up 4: rnd after warm-up is bit 27 of each seed, then bit 26
    b_seed_valid = 1'b1; b_seed_in = 32'h0800_0000;
    tick();
    chk("b_ready_w0", 32'(b_seed_ready), 32'h1);
    b_seed_in = 32'h0400_0000;
    tick();
    chk("b_ready_w1", 32'(b_seed_ready), 32'h1);
    b_seed_in = 32'h1C00_0000;
    tick();
    b_seed_valid = 1'b0;
    chk("b_ready_w2", 32'(b_seed_ready), 32'h0);
    chk("b_warm_valid0", 32'(b_rnd_valid), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("b_warm_valid", 32'(b_rnd_valid), 32'h0);
      chk("b_warm_rnd", 32'(b_rnd), 32'h0);
    end
    tick();
    chk("b_run_valid", 32'(b_rnd_valid), 32'h1);
    chk("b_run_rnd", 32'(b_rnd), 32'h5);
    b_rnd_ready = 1'b1;
    tick();
    b_rnd_ready = 1'b0;
    chk("b_run_rnd_step", 32'(b_rnd), 32'h6);
    chk("b_run_valid_step", 32'(b_rnd_valid), 32'h1);

    // Output limit of 4 handshakes
    c_seed_in = 32'h0000_0001; c_seed_valid = 1'b1;
    tick();
    c_seed_valid = 1'b0;
    c_rnd_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("c_valid_under_limit", 32'(c_rnd_valid), 32'h1);
      chk("c_exh_under_limit", 32'(c_exhausted), 32'h0);
    end
    tick();
    c_rnd_ready = 1'b0;
`ifdef MSK_RND_RESEED_LIMIT_EN
    chk("c_valid_at_limit", 32'(c_rnd_valid), 32'h0);
    chk("c_exh_at_limit", 32'(c_exhausted), 32'h1);
    tick();
    chk("c_exh_hold", 32'(c_exhausted), 32'h1);
    chk("c_rnd_hidden", 32'(c_rnd), 32'h0);
    c_reseed = 1'b1;
    tick();
    c_reseed = 1'b0;
    chk("c_exh_cleared", 32'(c_exhausted), 32'h0);
    chk("c_reseed_seed_ready", 32'(c_seed_ready), 32'h1);
`else
    chk("c_valid_no_limit", 32'(c_rnd_valid), 32'h1);
    chk("c_exh_tied", 32'(c_exhausted), 32'h0);
`endif

    // Reset mid-seeding discards the partial seed
    b_reseed = 1'b1;
    tick();
    b_reseed = 1'b0;
    chk("b_reseed_ready", 32'(b_seed_ready), 32'h1);
    b_seed_in = 32'hFFFF_FFFF; b_seed_valid = 1'b1;
    tick();
    b_seed_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("b_midrst_ready", 32'(b_seed_ready), 32'h0);
    chk("b_midrst_valid", 32'(b_rnd_valid), 32'h0);
    rst = 1'b0;
    tick();
    chk("b_midrst_release", 32'(b_seed_ready), 32'h1);
    b_seed_valid = 1'b1; b_seed_in = 32'h0800_0000;
    tick();
    b_seed_in = 32'h0400_0000;
    tick();
    chk("b_reseed_idx_restart", 32'(b_seed_ready), 32'h1);
    b_seed_in = 32'h1C00_0000;
    tick();
    b_seed_valid = 1'b0;
    chk("b_reseed_done", 32'(b_seed_ready), 32'h0);
    repeat (4) tick();
    chk("b_reseed_run_valid", 32'(b_rnd_valid), 32'h1);
    chk("b_reseed_run_rnd", 32'(b_rnd), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
